// File: rtl/gate_bist_pkg.sv
// Shared definitions for the gate BIST sequencer.
// Holds the FSM state encoding and the truth tables for common 2-input gates.
// TT_x[{a,b}] is the expected gate output for inputs a and b.
package gate_bist_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRIVE = 2'd1,
        S_CHECK = 2'd2,
        S_FIN   = 2'd3
    } state_t;

    localparam logic [3:0] TT_AND = 4'b1000;
    localparam logic [3:0] TT_OR  = 4'b1110;
    localparam logic [3:0] TT_XOR = 4'b0110;

endpackage

// File: rtl/gate_bist_hold_timer.sv
// Hold timer for the gate BIST sequencer.
// Measures how long each test vector stays on the gate inputs.
// Ports:
//   clk     - rising-edge clock
//   rst     - asynchronous active-high reset
//   load    - while high, keeps the count at zero
//   expired - high during the last cycle of a HOLD-cycle interval
module bist_hold_timer #(
    parameter int unsigned HOLD = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic expired
);

    logic [7:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 8'd1;
        end
    end

    // Released from load on the first hold cycle, so cnt runs 0..HOLD-1.
    assign expired = (cnt == 8'(HOLD - 1));

endmodule

// File: rtl/gate_bist.sv
// Self-test sequencer for a 2-input, 1-output combinational gate.
// Applies the vectors 00, 01, 10, 11 in turn and holds each one for HOLD cycles.
// Checks the gate output against TRUTH once per vector, then reports the result.
// Ports:
//   clk       - rising-edge clock
//   rst       - asynchronous active-high reset
//   start     - one-cycle request to begin a run; ignored while busy
//   dut_s     - output of the gate under test
//   dut_a     - gate input a
//   dut_b     - gate input b
//   busy      - high while a run is in progress
//   done      - high from the end of a run until the next accepted start
//   pass      - when done is high, 1 means no mismatches were seen
//   fail_vec  - when done is high, {a,b} of the first mismatching vector (00 if none)
//   err_count - number of mismatching vectors, 0..4
module gate_bist
    import gate_bist_pkg::*;
#(
    parameter logic [3:0]  TRUTH = TT_AND,
    parameter int unsigned HOLD  = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       dut_s,
    output logic       dut_a,
    output logic       dut_b,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [1:0] fail_vec,
    output logic [2:0] err_count
);

    state_t     state;
    state_t     next_state;
    logic [1:0] vec;
    logic       load;
    logic       expired;
    logic       mismatch;

    // The timer only runs in DRIVE, so every DRIVE visit starts at zero.
    assign load     = (state != S_DRIVE);
    assign mismatch = (dut_s != TRUTH[vec]);

    bist_hold_timer #(
        .HOLD(HOLD)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .load   (load),
        .expired(expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:  if (start)   next_state = S_DRIVE;
            S_DRIVE: if (expired) next_state = S_CHECK;
            S_CHECK: next_state = (vec == 2'd3) ? S_FIN : S_DRIVE;
            S_FIN:   next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vec       <= '0;
            dut_a     <= 1'b0;
            dut_b     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            fail_vec  <= '0;
            err_count <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        vec            <= '0;
                        {dut_a, dut_b} <= 2'b00;
                        busy           <= 1'b1;
                        done           <= 1'b0;
                        pass           <= 1'b0;
                        fail_vec       <= '0;
                        err_count      <= '0;
                    end
                end
                S_CHECK: begin
                    // dut_s still reflects vec here; the vector advances only afterwards.
                    if (mismatch) begin
                        err_count <= err_count + 3'd1;
                        if (err_count == 3'd0) begin
                            fail_vec <= vec;
                        end
                    end
                    if (vec == 2'd3) begin
                        {dut_a, dut_b} <= 2'b00;
                    end else begin
                        vec            <= vec + 2'd1;
                        {dut_a, dut_b} <= vec + 2'd1;
                    end
                end
                S_FIN: begin
                    busy <= 1'b0;
                    done <= 1'b1;
                    pass <= (err_count == 3'd0);
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gate_bist.sv
module tb_gate_bist;
    import gate_bist_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start0 = 1'b0;
    logic       start1 = 1'b0;
    logic       s0, s1;
    logic       a0, b0, busy0, done0, pass0;
    logic [1:0] fv0;
    logic [2:0] ec0;
    logic       a1, b1, busy1, done1, pass1;
    logic [1:0] fv1;
    logic [2:0] ec1;
    int         mode = 0;   // 0 and, 1 or, 2 tied low, 3 xor
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    always_comb begin
        case (mode)
            0:       s0 = a0 & b0;
            1:       s0 = a0 | b0;
            2:       s0 = 1'b0;
            default: s0 = a0 ^ b0;
        endcase
    end
    assign s1 = a1 ^ b1;

    gate_bist #(.TRUTH(TT_AND), .HOLD(10)) u_dut (
        .clk(clk), .rst(rst), .start(start0), .dut_s(s0),
        .dut_a(a0), .dut_b(b0), .busy(busy0), .done(done0), .pass(pass0),
        .fail_vec(fv0), .err_count(ec0)
    );

    gate_bist #(.TRUTH(TT_XOR), .HOLD(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .dut_s(s1),
        .dut_a(a1), .dut_b(b1), .busy(busy1), .done(done1), .pass(pass1),
        .fail_vec(fv1), .err_count(ec1)
    );

    // Raises start so that the next rising edge (edge 0) samples it.
    task automatic pulse_start(input int sel);
        @(negedge clk);
        if (sel == 0) start0 = 1'b1; else start1 = 1'b1;
        @(posedge clk);
        #1;
        start0 = 1'b0;
        start1 = 1'b0;
    endtask

    // Counts edges after edge 0 until done; -1 if the bound runs out.
    task automatic wait_done(input int sel, output int n);
        n = -1;
        for (int i = 1; i <= 200; i++) begin
            @(posedge clk);
            #1;
            if ((sel == 0 && done0) || (sel == 1 && done1)) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic test_reset;
        checks++;
        if ({a0, b0, busy0, done0, pass0, fv0, ec0} !== 10'b0) begin
            errors++;
            $display("FAIL reset_state got %b need 0", {a0, b0, busy0, done0, pass0, fv0, ec0});
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_and_pass;
        int n = -1;
        logic [1:0] ab [4];
        mode = 0;
        pulse_start(0);
        for (int i = 1; i <= 200; i++) begin
            @(posedge clk);
            #1;
            if ((i - 5) % 11 == 0 && i <= 38) ab[(i - 5) / 11] = {a0, b0};
            if (i == 44) begin
                checks++;
                if (done0 !== 1'b0) begin
                    errors++;
                    $display("FAIL and_done_early got %b need 0", done0);
                end
            end
            if (done0) begin
                n = i;
                break;
            end
        end
        checks++;
        if (n != 45) begin errors++; $display("FAIL and_latency got %0d need 45", n); end
        for (int v = 0; v < 4; v++) begin
            checks++;
            if (ab[v] !== 2'(v)) begin
                errors++;
                $display("FAIL and_vec%0d got %b need %b", v, ab[v], 2'(v));
            end
        end
        checks++;
        if ({pass0, ec0, fv0, a0, b0, busy0} !== {1'b1, 3'd0, 2'b00, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL and_result got pass=%b err=%0d fv=%b ab=%b%b busy=%b need 1 0 00 00 0",
                     pass0, ec0, fv0, a0, b0, busy0);
        end
    endtask

    task automatic test_or_fail;
        int n;
        mode = 1;
        pulse_start(0);
        wait_done(0, n);
        checks++;
        if (n != 45 || pass0 !== 1'b0 || ec0 !== 3'd2 || fv0 !== 2'b01) begin
            errors++;
            $display("FAIL or_result got n=%0d pass=%b err=%0d fv=%b need 45 0 2 01", n, pass0, ec0, fv0);
        end
    endtask

    task automatic test_tied_low;
        int n;
        mode = 2;
        pulse_start(0);
        wait_done(0, n);
        checks++;
        if (n != 45 || pass0 !== 1'b0 || ec0 !== 3'd1 || fv0 !== 2'b11) begin
            errors++;
            $display("FAIL tied_low got n=%0d pass=%b err=%0d fv=%b need 45 0 1 11", n, pass0, ec0, fv0);
        end
    endtask

    task automatic test_reset_midrun;
        int n;
        mode = 1;   // leaves err_count nonzero before reset hits
        pulse_start(0);
        repeat (27) @(posedge clk);
        #2;
        checks++;
        if ({a0, b0} !== 2'b10 || ec0 !== 3'd1) begin
            errors++;
            $display("FAIL midrun_pre got ab=%b%b err=%0d need 10 1", a0, b0, ec0);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({busy0, a0, b0, ec0, done0} !== 7'b0) begin
            errors++;
            $display("FAIL midrun_reset got busy=%b ab=%b%b err=%0d done=%b need 0 00 0 0",
                     busy0, a0, b0, ec0, done0);
        end
        @(negedge clk);
        rst = 1'b0;
        mode = 0;
        pulse_start(0);
        wait_done(0, n);
        checks++;
        if (n != 45 || pass0 !== 1'b1 || ec0 !== 3'd0) begin
            errors++;
            $display("FAIL after_reset got n=%0d pass=%b err=%0d need 45 1 0", n, pass0, ec0);
        end
    endtask

    task automatic test_back_to_back;
        int n = -1;
        mode = 1;
        pulse_start(0);
        for (int i = 1; i <= 200; i++) begin
            if (i == 17) start0 = 1'b1;   // sampled at edge 17, during vector 01
            @(posedge clk);
            #1;
            start0 = 1'b0;
            if (done0) begin
                n = i;
                break;
            end
        end
        checks++;
        if (n != 45 || ec0 !== 3'd2) begin
            errors++;
            $display("FAIL busy_start got n=%0d err=%0d need 45 2", n, ec0);
        end
        pulse_start(0);
        checks++;
        if ({done0, pass0, ec0, fv0, busy0} !== {1'b0, 1'b0, 3'd0, 2'b00, 1'b1}) begin
            errors++;
            $display("FAIL restart_clear got done=%b pass=%b err=%0d fv=%b busy=%b need 0 0 0 00 1",
                     done0, pass0, ec0, fv0, busy0);
        end
        wait_done(0, n);
    endtask

    task automatic test_hold1;
        int n;
        pulse_start(1);
        wait_done(1, n);
        checks++;
        if (n != 9 || pass1 !== 1'b1 || ec1 !== 3'd0 || fv1 !== 2'b00) begin
            errors++;
            $display("FAIL hold1 got n=%0d pass=%b err=%0d fv=%b need 9 1 0 00", n, pass1, ec1, fv1);
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        test_reset;
        test_and_pass;
        test_or_fail;
        test_tied_low;
        test_reset_midrun;
        test_back_to_back;
        test_hold1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
